// File: rtl/rob_core.sv
// rob_core: reorder buffer with in-order allocate/commit, out-of-order writeback and mispredict flush.
//   clk, rst_n                                   : clock, async active-low reset
//   alloc_valid/alloc_entry -> alloc_ready/idx   : dispatch at the tail
//   wb_valid/wb_idx/wb_result/wb_taken/wb_target : completion by index
//   commit_valid/commit_entry <- commit_ready    : in-order retire at the head
//   flush_out/redirect_pc                        : registered mispredict flush and fetch redirect
//   count                                        : occupied entries
package general_defines;
    localparam int ROB_LENGTH      = 16;
    localparam int ROB_IDX_W       = $clog2(ROB_LENGTH);
    localparam int INT_DATA_W      = 32;
    localparam int INSTR_MEM_IDX_W = 8;
    typedef struct packed {
        logic                       valid;
        logic                       done;
        logic                       is_branch;
        logic                       pred_taken;
        logic [INSTR_MEM_IDX_W-1:0] pred_target;
        logic [INSTR_MEM_IDX_W-1:0] pc;
        logic [4:0]                 rd;
        logic [INT_DATA_W-1:0]      result;
    } rob_entry_t;
endpackage

module rob_core
    import general_defines::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alloc_valid,
    input  rob_entry_t                 alloc_entry,
    output logic                       alloc_ready,
    output logic [ROB_IDX_W-1:0]       alloc_idx,
    input  logic                       wb_valid,
    input  logic [ROB_IDX_W-1:0]       wb_idx,
    input  logic [INT_DATA_W-1:0]      wb_result,
    input  logic                       wb_taken,
    input  logic [INSTR_MEM_IDX_W-1:0] wb_target,
    output logic                       commit_valid,
    output rob_entry_t                 commit_entry,
    input  logic                       commit_ready,
    output logic                       flush_out,
    output logic [INSTR_MEM_IDX_W-1:0] redirect_pc,
    output logic [ROB_IDX_W:0]         count
);
    localparam logic [ROB_IDX_W:0] FULL = (ROB_IDX_W+1)'(ROB_LENGTH);
    rob_entry_t                 entries_q [ROB_LENGTH];
    logic [ROB_LENGTH-1:0]      act_taken_q;
    logic [INSTR_MEM_IDX_W-1:0] act_target_q [ROB_LENGTH];
    logic [ROB_IDX_W-1:0]       head_q, head_d, tail_q, tail_d;
    logic [ROB_IDX_W:0]         count_q, count_d;
    logic                       flush_q, flush_d;
    logic [INSTR_MEM_IDX_W-1:0] redirect_q, redirect_d, correct_pc;
    rob_entry_t                 hd;
    logic                       alloc_fire, commit_fire, mispredict, act_taken;
    logic [INSTR_MEM_IDX_W-1:0] act_target;

    always_comb begin
        hd          = entries_q[head_q];
        act_taken   = act_taken_q[head_q];
        act_target  = act_target_q[head_q];
        alloc_ready = (count_q != FULL) && !flush_q;
        alloc_fire  = alloc_valid && alloc_ready;
        commit_valid = hd.valid && hd.done && !flush_q;
        commit_fire = commit_valid && commit_ready;
        mispredict  = commit_fire && hd.is_branch &&
                      ((act_taken != hd.pred_taken) || (act_taken && act_target != hd.pred_target));
        correct_pc  = act_taken ? act_target : hd.pc + INSTR_MEM_IDX_W'(1);
        head_d      = mispredict ? '0 : head_q + ROB_IDX_W'(commit_fire);
        tail_d      = mispredict ? '0 : tail_q + ROB_IDX_W'(alloc_fire);
        count_d     = mispredict ? '0 : count_q + (ROB_IDX_W+1)'(alloc_fire) - (ROB_IDX_W+1)'(commit_fire);
        flush_d     = mispredict;
        redirect_d  = mispredict ? correct_pc : redirect_q;
    end

    assign alloc_idx    = tail_q;
    assign commit_entry = hd;
    assign flush_out    = flush_q;
    assign redirect_pc  = redirect_q;
    assign count        = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROB_LENGTH; i++) begin
                entries_q[i]    <= '0;
                act_target_q[i] <= '0;
            end
            act_taken_q <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            flush_q     <= 1'b0;
            redirect_q  <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            if (alloc_fire) begin
                entries_q[tail_q]       <= alloc_entry;
                entries_q[tail_q].valid <= 1'b1;
                // Seed actual outcome with the prediction so a branch dispatched already-done never mispredicts.
                act_taken_q[tail_q]     <= alloc_entry.pred_taken;
                act_target_q[tail_q]    <= alloc_entry.pred_target;
            end
            if (wb_valid && entries_q[wb_idx].valid) begin
                entries_q[wb_idx].result <= wb_result;
                entries_q[wb_idx].done   <= 1'b1;
                act_taken_q[wb_idx]      <= wb_taken;
                act_target_q[wb_idx]     <= wb_target;
            end
            if (commit_fire) entries_q[head_q].valid <= 1'b0;
            if (mispredict) begin
                for (int i = 0; i < ROB_LENGTH; i++) begin
                    entries_q[i].valid <= 1'b0;
                    entries_q[i].done  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_rob_core.sv
// tb_rob_core: directed self-checking bench for rob_core.
module tb_rob_core;
    import general_defines::*;
    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       alloc_valid;
    rob_entry_t                 alloc_entry;
    logic                       alloc_ready;
    logic [ROB_IDX_W-1:0]       alloc_idx;
    logic                       wb_valid;
    logic [ROB_IDX_W-1:0]       wb_idx;
    logic [INT_DATA_W-1:0]      wb_result;
    logic                       wb_taken;
    logic [INSTR_MEM_IDX_W-1:0] wb_target;
    logic                       commit_valid;
    rob_entry_t                 commit_entry;
    logic                       commit_ready;
    logic                       flush_out;
    logic [INSTR_MEM_IDX_W-1:0] redirect_pc;
    logic [ROB_IDX_W:0]         count;
    int passed = 0;
    int total  = 0;

    rob_core dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_entry(alloc_entry), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_result(wb_result), .wb_taken(wb_taken), .wb_target(wb_target),
        .commit_valid(commit_valid), .commit_entry(commit_entry), .commit_ready(commit_ready),
        .flush_out(flush_out), .redirect_pc(redirect_pc), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic rob_entry_t mk(input logic [7:0] pc, input logic br, input logic pt,
                                      input logic [7:0] ptg, input logic dn);
        rob_entry_t e;
        e = '0;
        e.pc = pc;
        e.is_branch = br;
        e.pred_taken = pt;
        e.pred_target = ptg;
        e.done = dn;
        return e;
    endfunction

    initial begin
        rst_n = 1'b0; alloc_valid = 1'b0; alloc_entry = '0; wb_valid = 1'b0; wb_idx = '0;
        wb_result = '0; wb_taken = 1'b0; wb_target = '0; commit_ready = 1'b0;
        tick(); tick();
        chk("rst_count", 64'(count), 0);
        chk("rst_alloc_ready", 64'(alloc_ready), 1);
        chk("rst_alloc_idx", 64'(alloc_idx), 0);
        chk("rst_commit_valid", 64'(commit_valid), 0);
        chk("rst_commit_entry", 64'(commit_entry), 0);
        chk("rst_flush", 64'(flush_out), 0);
        chk("rst_redirect", 64'(redirect_pc), 0);
        rst_n = 1'b1;
        // Fill to capacity
        for (int i = 0; i < 16; i++) begin
            alloc_valid = 1'b1;
            alloc_entry = mk(8'(i), 1'b0, 1'b0, 8'h0, 1'b0);
            chk("fill_idx", 64'(alloc_idx), 64'(i));
            chk("fill_ready", 64'(alloc_ready), 1);
            tick();
        end
        chk("full_count", 64'(count), 16);
        chk("full_ready", 64'(alloc_ready), 0);
        chk("full_cv", 64'(commit_valid), 0);
        alloc_entry = mk(8'hEE, 1'b0, 1'b0, 8'h0, 1'b1);
        tick();
        chk("full_ignored_count", 64'(count), 16);
        chk("full_ignored_head_pc", 64'(commit_entry.pc), 0);
        alloc_valid = 1'b0;
        // Asynchronous reset mid-operation
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", 64'(count), 0);
        chk("async_rst_ready", 64'(alloc_ready), 1);
        chk("async_rst_entry", 64'(commit_entry), 0);
        tick();
        rst_n = 1'b1;
        // Out-of-order completion
        commit_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1'b1;
            alloc_entry = mk(8'(i), 1'b0, 1'b0, 8'h0, 1'b0);
            tick();
        end
        alloc_valid = 1'b0;
        wb_valid = 1'b1; wb_idx = 4'd2; wb_result = 32'h33;
        tick();
        chk("ooo_cv_after_wb2", 64'(commit_valid), 0);
        wb_idx = 4'd0; wb_result = 32'h11;
        tick();
        chk("ooo_cv0", 64'(commit_valid), 1);
        chk("ooo_res0", 64'(commit_entry.result), 32'h11);
        wb_idx = 4'd1; wb_result = 32'h22;
        tick();
        wb_valid = 1'b0;
        chk("ooo_cv1", 64'(commit_valid), 1);
        chk("ooo_res1", 64'(commit_entry.result), 32'h22);
        chk("ooo_count2", 64'(count), 2);
        tick();
        chk("ooo_res2", 64'(commit_entry.result), 32'h33);
        chk("ooo_count1", 64'(count), 1);
        tick();
        chk("ooo_count0", 64'(count), 0);
        chk("ooo_cv_empty", 64'(commit_valid), 0);
        // Commit backpressure (entry at index 3, dispatched already done)
        commit_ready = 1'b0;
        alloc_valid = 1'b1;
        alloc_entry = mk(8'h55, 1'b0, 1'b0, 8'h0, 1'b1);
        tick();
        alloc_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_cv", 64'(commit_valid), 1);
            chk("bp_pc", 64'(commit_entry.pc), 8'h55);
            chk("bp_count", 64'(count), 1);
            tick();
        end
        commit_ready = 1'b1;
        tick();
        chk("bp_retired_count", 64'(count), 0);
        chk("bp_retired_cv", 64'(commit_valid), 0);
        // Wrap-around: head=tail=4; alloc k, complete k-1, commit k-2 each cycle
        for (int k = 0; k < 22; k++) begin
            alloc_valid = (k < 20);
            alloc_entry = mk(8'(8'h80 + k), 1'b0, 1'b0, 8'h0, 1'b0);
            if (k < 20) chk("wrap_idx", 64'(alloc_idx), 64'((4 + k) % 16));
            wb_valid = (k >= 1 && k <= 20);
            wb_idx = 4'((4 + k - 1) % 16);
            wb_result = 32'(k - 1);
            if (k >= 2) begin
                chk("wrap_cv", 64'(commit_valid), 1);
                chk("wrap_pc", 64'(commit_entry.pc), 64'(8'h80 + k - 2));
            end
            if (k >= 2 && k <= 20) chk("wrap_count", 64'(count), 2);
            tick();
        end
        alloc_valid = 1'b0; wb_valid = 1'b0;
        chk("wrap_drained", 64'(count), 0);
        chk("wrap_drained_cv", 64'(commit_valid), 0);
        // Mispredict: branch at idx 8 pc=0x10 predicted not-taken, resolves taken to 0x40
        alloc_valid = 1'b1;
        alloc_entry = mk(8'h10, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("mp_branch_idx", 64'(alloc_idx), 8);
        tick();
        for (int i = 0; i < 4; i++) begin
            alloc_entry = mk(8'(8'h11 + i), 1'b0, 1'b0, 8'h0, 1'b1);
            tick();
        end
        alloc_valid = 1'b0;
        chk("mp_cv_pending", 64'(commit_valid), 0);
        wb_valid = 1'b1; wb_idx = 4'd8; wb_result = 32'h0; wb_taken = 1'b1; wb_target = 8'h40;
        tick();
        wb_valid = 1'b0;
        chk("mp_cv", 64'(commit_valid), 1);
        chk("mp_head_pc", 64'(commit_entry.pc), 8'h10);
        chk("mp_count5", 64'(count), 5);
        alloc_valid = 1'b1;
        alloc_entry = mk(8'h99, 1'b0, 1'b0, 8'h0, 1'b1);
        tick();
        chk("mp_flush", 64'(flush_out), 1);
        chk("mp_redirect", 64'(redirect_pc), 8'h40);
        chk("mp_count0", 64'(count), 0);
        chk("mp_ready0", 64'(alloc_ready), 0);
        chk("mp_cv0", 64'(commit_valid), 0);
        alloc_valid = 1'b0;
        tick();
        chk("mp_flush_end", 64'(flush_out), 0);
        chk("mp_ready1", 64'(alloc_ready), 1);
        chk("mp_redirect_hold", 64'(redirect_pc), 8'h40);
        chk("mp_tail0", 64'(alloc_idx), 0);
        chk("mp_dropped", 64'(count), 0);
        // Mispredict predicted taken, resolves not-taken at pc=0xFF -> wraps to 0x00
        alloc_valid = 1'b1;
        alloc_entry = mk(8'hFF, 1'b1, 1'b1, 8'h30, 1'b0);
        tick();
        alloc_entry = mk(8'h01, 1'b0, 1'b0, 8'h0, 1'b1);
        tick();
        alloc_valid = 1'b0;
        wb_valid = 1'b1; wb_idx = 4'd0; wb_taken = 1'b0; wb_target = 8'h77;
        tick();
        wb_valid = 1'b0;
        chk("mp2_cv", 64'(commit_valid), 1);
        tick();
        chk("mp2_flush", 64'(flush_out), 1);
        chk("mp2_redirect", 64'(redirect_pc), 8'h00);
        chk("mp2_count", 64'(count), 0);
        tick();
        chk("mp2_flush_end", 64'(flush_out), 0);
        // Correct prediction: taken to 0x20 as predicted
        alloc_valid = 1'b1;
        alloc_entry = mk(8'h05, 1'b1, 1'b1, 8'h20, 1'b0);
        tick();
        alloc_entry = mk(8'h06, 1'b0, 1'b0, 8'h0, 1'b1);
        tick();
        alloc_entry = mk(8'h07, 1'b0, 1'b0, 8'h0, 1'b1);
        tick();
        alloc_valid = 1'b0;
        wb_valid = 1'b1; wb_idx = 4'd0; wb_taken = 1'b1; wb_target = 8'h20;
        tick();
        wb_valid = 1'b0;
        chk("ok_branch_pc", 64'(commit_entry.pc), 8'h05);
        tick();
        chk("ok_no_flush", 64'(flush_out), 0);
        chk("ok_cv", 64'(commit_valid), 1);
        chk("ok_young1", 64'(commit_entry.pc), 8'h06);
        chk("ok_count2", 64'(count), 2);
        tick();
        chk("ok_young2", 64'(commit_entry.pc), 8'h07);
        tick();
        chk("ok_count0", 64'(count), 0);
        chk("ok_redirect_hold", 64'(redirect_pc), 8'h00);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
